cache_axi_rd_arbiter: RTL and testbench
=======================================

Name: cache_axi_rd_arbiter

Overview:
Shares the single AXI read-address/read-data channel between the icache and dcache line-refill ports. Each requester uses the same r_req/r_addr/r_rdy/ret_valid/ret_last/r_data_ready handshake the caches already drive. The block sits between both caches and the AXI bridge. It snoops the dcache write channel so that a refill is never issued for a line whose writeback is still outstanding (read-after-write hazard).

Parameters:
LINE_BEATS, 16, 32-bit beats per cache line (512-bit line); drives arlen = LINE_BEATS-1
ADDR_W, 32, address width
LINE_OFF, 6, byte-offset bits per line; the hazard compare uses addr[ADDR_W-1:LINE_OFF]

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
i_r_req, d_r_req  in  1  refill request from icache / dcache; held until the matching *_r_rdy
i_r_addr, d_r_addr  in  ADDR_W  line start address, stable while the request is held
i_r_rdy, d_r_rdy  out  1  one-cycle pulse: AR handshake completed for that requester
i_ret_valid, d_ret_valid  out  1  returned beat valid, routed to the granted requester only
i_ret_last, d_ret_last  out  1  last beat, routed to the granted requester only
i_r_data, d_r_data  out  32  rdata broadcast to both; qualified by *_ret_valid
i_r_data_ready, d_r_data_ready  in  1  requester ready to take a beat
arvalid  out  1; arready  in  1; araddr  out  ADDR_W; arlen  out  8; arsize  out  3; arburst  out  2
rvalid  in  1; rready  out  1; rdata  in  32; rlast  in  1
mon_awvalid, mon_awready  in  1  snoop of dcache AW handshake
mon_awaddr  in  ADDR_W  snoop of dcache writeback address
mon_bvalid, mon_bready  in  1  snoop of B handshake
protocol_err  out  1  sticky error flag, cleared only by rst

Behaviour:
- Reset: state IDLE; last_grant = ICACHE, so dcache wins the first tie. All outputs 0; arlen, arsize and arburst are constants. wr_pending = 0; beat_cnt = 0.
- Write tracker:
  - wr_pending is set, and wr_line latched from mon_awaddr line bits, on mon_awvalid & mon_awready.
  - wr_pending is cleared on mon_bvalid & mon_bready.
  - AW and B handshakes in the same cycle: pending stays 1 with the new line.
  - AW handshake while pending with no B in that cycle: protocol_err set.
- Eligibility: X eligible = x_r_req & !(wr_pending & x_r_addr line bits == wr_line).
- IDLE:
  - Both eligible: grant the requester that is not last_grant.
  - One eligible: grant it.
  - On grant: latch address and grant id; go AR. The earliest arvalid is the cycle after the request.
- AR:
  - arvalid = 1; araddr = latched address; arlen = LINE_BEATS-1; arsize = 3'b010; arburst = 2'b01 (INCR).
  - arvalid is never dropped before arready.
  - On arvalid & arready: the granted *_r_rdy = 1 in that same cycle (combinational from the handshake); beat_cnt = 0; go R.
- R:
  - rready = granted *_r_data_ready; granted *_ret_valid = rvalid; granted *_ret_last = rlast.
  - The non-granted requester sees ret_valid = ret_last = 0.
  - beat_cnt increments on each rvalid & rready.
  - On the accepted beat with rlast: last_grant = granted id; go IDLE. The next AR can issue one cycle later.
  - rlast with beat_cnt != LINE_BEATS-1, or beat LINE_BEATS-1 accepted without rlast: protocol_err set. The burst still terminates only on rlast.
- Hazard is evaluated only in IDLE. A grant already issued is not revoked by a later AW.
- Requester drops request before r_rdy: if still in IDLE it is not granted. In AR the transfer completes and the data is discarded via the requester's own ready.
- rst mid-AR or mid-R: return to IDLE immediately; the downstream bridge is reset by the same rst.
- Latency from a lone request in IDLE with arready held 1: arvalid at T+1, r_rdy at T+1.

Decomposition:
- Shared package cache_axi_pkg:
  - LINE_BEATS, LINE_OFF
  - AXI_BURST_INCR = 2'b01, AXI_SIZE_4B = 3'b010
  - grant id enum {ICACHE, DCACHE}
  - rd_arb_state enum {IDLE, AR, R}
- One sub-module: wr_line_tracker, holding wr_pending, wr_line, the compare for both addresses, and the double-AW error.

Test Plan:
- Lone icache request 0x0000_1040, arready=1, 16 beats rdata=k, last on beat 15 -> araddr=0x0000_1040, arlen=15, arsize=2, arburst=1; i_r_rdy pulses once; 16 i_ret_valid; i_ret_last on beat 15 only; d_ret_valid stays 0.
- Simultaneous i/d requests after reset -> dcache granted first. Both re-request continuously -> grants alternate D, I, D, I over 4 bursts.
- Writeback AW 0x0000_2000 accepted, then d_r_req 0x0000_2000 -> no arvalid until the B handshake. arvalid the cycle after B; an icache request to 0x0000_3000 in the meantime is served first.
- Granted requester deasserts ready on beats 3-5 -> rready low for exactly those cycles; no beat lost or duplicated; beat_cnt ends at 15.
- rlast on beat 9 -> burst ends; protocol_err = 1 and stays 1 until rst. A second AW while pending also sets it.
- rst asserted in R at beat 7 -> next cycle state IDLE, all outputs 0, protocol_err 0; a fresh request is served normally.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared constants and enums for the cache AXI read arbiter
package cache_axi_pkg;
    localparam int LINE_BEATS = 16;
    localparam int LINE_OFF = 6;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} grant_id_t;
    typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} rd_arb_state_t;
endpackage

// File: rtl/wr_line_tracker.sv
// wr_line_tracker: tracks the outstanding dcache writeback line and flags refill hazards
module wr_line_tracker #(
    parameter int ADDR_W = 32,
    parameter int LINE_OFF = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_awvalid,
    input  logic              mon_awready,
    input  logic [ADDR_W-1:0] mon_awaddr,
    input  logic              mon_bvalid,
    input  logic              mon_bready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              o_i_hit,
    output logic              o_d_hit,
    output logic              o_dbl_aw
);
    localparam int LW = ADDR_W - LINE_OFF;
    logic          r_pending;
    logic [LW-1:0] r_line;
    logic          w_aw_hs;
    logic          w_b_hs;
    logic          w_pend_nxt;
    logic [LW-1:0] w_line_nxt;
    logic          w_unused_low;
    assign w_unused_low = ^{mon_awaddr[LINE_OFF-1:0], i_addr[LINE_OFF-1:0], d_addr[LINE_OFF-1:0]};
    // compare against the next-cycle write state: a retiring B unblocks at once, a new AW blocks at once
    always_comb begin
        w_aw_hs = mon_awvalid & mon_awready;
        w_b_hs = mon_bvalid & mon_bready;
        w_pend_nxt = w_aw_hs | (r_pending & ~w_b_hs);
        w_line_nxt = w_aw_hs ? mon_awaddr[ADDR_W-1:LINE_OFF] : r_line;
        o_i_hit = w_pend_nxt & (i_addr[ADDR_W-1:LINE_OFF] == w_line_nxt);
        o_d_hit = w_pend_nxt & (d_addr[ADDR_W-1:LINE_OFF] == w_line_nxt);
        o_dbl_aw = w_aw_hs & r_pending & ~w_b_hs;
    end
    // pending flag and line of the single outstanding writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_line <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_line <= w_line_nxt;
        end
    end
endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: shares one AXI read channel between icache and dcache line refills
module cache_axi_rd_arbiter #(
    parameter int LINE_BEATS = cache_axi_pkg::LINE_BEATS,
    parameter int ADDR_W = 32,
    parameter int LINE_OFF = cache_axi_pkg::LINE_OFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_r_req,
    input  logic              d_r_req,
    input  logic [ADDR_W-1:0] i_r_addr,
    input  logic [ADDR_W-1:0] d_r_addr,
    output logic              i_r_rdy,
    output logic              d_r_rdy,
    output logic              i_ret_valid,
    output logic              d_ret_valid,
    output logic              i_ret_last,
    output logic              d_ret_last,
    output logic [31:0]       i_r_data,
    output logic [31:0]       d_r_data,
    input  logic              i_r_data_ready,
    input  logic              d_r_data_ready,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic              mon_awvalid,
    input  logic              mon_awready,
    input  logic [ADDR_W-1:0] mon_awaddr,
    input  logic              mon_bvalid,
    input  logic              mon_bready,
    output logic              protocol_err
);
    import cache_axi_pkg::*;
    localparam logic [7:0] LAST_BEAT = 8'(LINE_BEATS - 1);
    rd_arb_state_t     r_state, w_state_nxt;
    grant_id_t         r_grant, r_last_grant, w_grant_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_beat_cnt;
    logic              r_err;
    logic              w_i_hit, w_d_hit, w_dbl_aw;
    logic              w_i_elig, w_d_elig, w_gnt_i, w_grant_go;
    logic              w_ar_hs, w_r_hs, w_beat_err;
    assign arlen = LAST_BEAT;
    assign arsize = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign i_r_data = rdata;
    assign d_r_data = rdata;
    assign protocol_err = r_err;
    wr_line_tracker #(.ADDR_W(ADDR_W), .LINE_OFF(LINE_OFF)) u_wr_line_tracker (
        .clk(clk),
        .rst(rst),
        .mon_awvalid(mon_awvalid),
        .mon_awready(mon_awready),
        .mon_awaddr(mon_awaddr),
        .mon_bvalid(mon_bvalid),
        .mon_bready(mon_bready),
        .i_addr(i_r_addr),
        .d_addr(d_r_addr),
        .o_i_hit(w_i_hit),
        .o_d_hit(w_d_hit),
        .o_dbl_aw(w_dbl_aw)
    );
    // arbitration, AR issue and beat routing for the granted requester
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_grant_go = 1'b0;
        w_ar_hs = 1'b0;
        w_r_hs = 1'b0;
        w_beat_err = 1'b0;
        arvalid = 1'b0;
        araddr = '0;
        rready = 1'b0;
        i_r_rdy = 1'b0;
        d_r_rdy = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        i_ret_last = 1'b0;
        d_ret_last = 1'b0;
        w_i_elig = i_r_req & ~w_i_hit;
        w_d_elig = d_r_req & ~w_d_hit;
        w_gnt_i = (r_grant == ICACHE);
        case (r_state)
            IDLE: begin
                if (w_i_elig | w_d_elig) begin
                    w_grant_go = 1'b1;
                    w_grant_nxt = (w_i_elig & w_d_elig) ? ((r_last_grant == ICACHE) ? DCACHE : ICACHE)
                                                        : (w_d_elig ? DCACHE : ICACHE);
                    w_state_nxt = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                araddr = r_addr;
                w_ar_hs = arready;
                i_r_rdy = arready & w_gnt_i;
                d_r_rdy = arready & ~w_gnt_i;
                if (arready) w_state_nxt = R;
            end
            R: begin
                rready = w_gnt_i ? i_r_data_ready : d_r_data_ready;
                i_ret_valid = w_gnt_i & rvalid;
                d_ret_valid = ~w_gnt_i & rvalid;
                i_ret_last = w_gnt_i & rlast;
                d_ret_last = ~w_gnt_i & rlast;
                w_r_hs = rvalid & rready;
                w_beat_err = w_r_hs & (rlast != (r_beat_cnt == LAST_BEAT));
                if (w_r_hs & rlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    // state, grant bookkeeping, beat counter and sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= ICACHE;
            r_last_grant <= ICACHE;
            r_addr <= '0;
            r_beat_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_grant_go) r_addr <= (w_grant_nxt == DCACHE) ? d_r_addr : i_r_addr;
            if (w_ar_hs) r_beat_cnt <= '0;
            else if (w_r_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_r_hs & rlast) r_last_grant <= r_grant;
            if (w_beat_err | w_dbl_aw) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb_cache_axi_rd_arbiter: randomized self-checking bench with a transaction-level arbiter model
module tb_cache_axi_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_r_req, d_r_req;
    logic [31:0] i_r_addr, d_r_addr;
    logic        i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
    logic [31:0] i_r_data, d_r_data;
    logic        i_r_data_ready, d_r_data_ready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic        mon_awvalid, mon_awready, mon_bvalid, mon_bready;
    logic [31:0] mon_awaddr;
    logic        protocol_err;
    int          vectors, miscompares;
    int          m_last;
    bit          m_err;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .i_r_req(i_r_req), .d_r_req(d_r_req), .i_r_addr(i_r_addr), .d_r_addr(d_r_addr),
        .i_r_rdy(i_r_rdy), .d_r_rdy(d_r_rdy),
        .i_ret_valid(i_ret_valid), .d_ret_valid(d_ret_valid),
        .i_ret_last(i_ret_last), .d_ret_last(d_ret_last),
        .i_r_data(i_r_data), .d_r_data(d_r_data),
        .i_r_data_ready(i_r_data_ready), .d_r_data_ready(d_r_data_ready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .mon_awvalid(mon_awvalid), .mon_awready(mon_awready), .mon_awaddr(mon_awaddr),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
        .protocol_err(protocol_err)
    );

    // arbitration rule: tie goes to whoever was not served last; 0 = icache, 1 = dcache, -1 = none
    function automatic int pick(bit ie, bit de, int last);
        if (ie && de) return (last == 0) ? 1 : 0;
        if (de) return 1;
        if (ie) return 0;
        return -1;
    endfunction

    function automatic logic [31:0] rand_line();
        return $urandom() & 32'hFFFF_FFC0;
    endfunction

    task automatic idle_inputs();
        i_r_req = 0; d_r_req = 0; i_r_addr = 0; d_r_addr = 0;
        i_r_data_ready = 1; d_r_data_ready = 1;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0;
        mon_awvalid = 0; mon_awready = 0; mon_awaddr = 0; mon_bvalid = 0; mon_bready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_last = 0;
        m_err = 0;
    endtask

    task automatic wb_cycle(input bit aw, input bit b, input logic [31:0] addr);
        mon_awvalid = aw; mon_awready = aw; mon_awaddr = addr;
        mon_bvalid = b; mon_bready = b;
        @(negedge clk);
        mon_awvalid = 0; mon_awready = 0; mon_bvalid = 0; mon_bready = 0;
    endtask

    task automatic expect_no_ar(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            #1;
            vectors++;
            if (arvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s arvalid=%b exp=0 cycle %0d", tag, arvalid, c);
            end
            @(negedge clk);
        end
    endtask

    task automatic ar_phase(input int id, input logic [31:0] addr, input bit fixed_rdy, input bit keep_req, output int hs_cyc);
        int  cyc;
        bit  seen, done;
        cyc = 0; seen = 0; done = 0; hs_cyc = -1;
        while (!done && cyc < 40) begin
            arready = fixed_rdy ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (seen) begin
                vectors++;
                if (arvalid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ar_hold arvalid=%b exp=1", arvalid);
                end
            end
            vectors++;
            if ({i_r_rdy, d_r_rdy} !== {arvalid && arready && id == 0, arvalid && arready && id == 1}) begin
                miscompares++;
                $display("FAIL r_rdy got i=%b d=%b exp_id=%0d arvalid=%b arready=%b", i_r_rdy, d_r_rdy, id, arvalid, arready);
            end
            if (arvalid === 1'b1) begin
                seen = 1;
                vectors++;
                if (araddr !== addr || arlen !== 8'd15 || arsize !== 3'd2 || arburst !== 2'd1) begin
                    miscompares++;
                    $display("FAIL ar_fields got addr=%h len=%0d size=%0d burst=%0d exp addr=%h len=15 size=2 burst=1",
                             araddr, arlen, arsize, arburst, addr);
                end
                if (arready) begin
                    done = 1;
                    hs_cyc = cyc;
                end
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                arready = 0;
                if (keep_req) begin
                    if (id == 0) i_r_addr = rand_line(); else d_r_addr = rand_line();
                end else begin
                    if (id == 0) i_r_req = 0; else d_r_req = 0;
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL ar_timeout got no handshake exp id=%0d addr=%h", id, addr);
        end
    endtask

    task automatic r_phase(input int id, input int last_at, input int mode, input int abort_at, input bit drop_other, output int lows);
        int          k, cyc, stall_k;
        bit          done, rdy, oth;
        logic [31:0] base;
        k = 0; cyc = 0; stall_k = -1; done = 0; lows = 0;
        base = $urandom;
        while (!done && cyc < 300 && !(abort_at >= 0 && k == abort_at)) begin
            rvalid = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdata = rvalid ? base + k : $urandom;
            rlast = rvalid && (k == last_at);
            rdy = (mode == 1) ? !(k >= 3 && k <= 5 && stall_k != k) : ($urandom_range(0, 3) != 0);
            if (mode == 1 && !rdy) stall_k = k;
            oth = $urandom_range(0, 1);
            if (id == 0) begin i_r_data_ready = rdy; d_r_data_ready = oth; end
            else begin d_r_data_ready = rdy; i_r_data_ready = oth; end
            if (drop_other && rvalid && rdy && rlast) begin
                if (id == 0) d_r_req = 0; else i_r_req = 0;
            end
            #1;
            if (rvalid && !rready) lows++;
            vectors++;
            if (rready !== rdy) begin
                miscompares++;
                $display("FAIL rready got=%b exp=%b beat %0d", rready, rdy, k);
            end
            vectors++;
            if ({i_ret_valid, d_ret_valid, i_ret_last, d_ret_last} !==
                {id == 0 && rvalid, id == 1 && rvalid, id == 0 && rlast, id == 1 && rlast}) begin
                miscompares++;
                $display("FAIL ret_route got iv=%b dv=%b il=%b dl=%b exp id=%0d valid=%b last=%b",
                         i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, id, rvalid, rlast);
            end
            vectors++;
            if (i_r_data !== rdata || d_r_data !== rdata) begin
                miscompares++;
                $display("FAIL r_data got i=%h d=%h exp=%h", i_r_data, d_r_data, rdata);
            end
            if (rvalid && rdy) begin
                if (rlast) done = 1;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        rvalid = 0; rlast = 0; i_r_data_ready = 1; d_r_data_ready = 1;
        if (abort_at < 0) begin
            if (last_at != 15) m_err = 1;
            m_last = id;
            vectors++;
            if (!done || k != last_at + 1) begin
                miscompares++;
                $display("FAIL burst_beats got=%0d done=%b exp=%0d", k, done, last_at + 1);
            end
            vectors++;
            if (protocol_err !== m_err) begin
                miscompares++;
                $display("FAIL burst_err got=%b exp=%b", protocol_err, m_err);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, protocol_err} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=000000000",
                     {arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, protocol_err});
        end
        vectors++;
        if (araddr !== 32'h0 || arlen !== 8'd15 || arsize !== 3'd2 || arburst !== 2'd1) begin
            miscompares++;
            $display("FAIL reset_ar got addr=%h len=%0d size=%0d burst=%0d exp 0/15/2/1", araddr, arlen, arsize, arburst);
        end
        @(negedge clk);
    endtask

    task automatic test_lone();
        int hs, lows;
        do_reset();
        i_r_req = 1; i_r_addr = 32'h0000_1040;
        ar_phase(0, 32'h0000_1040, 1, 0, hs);
        vectors++;
        if (hs !== 1) begin
            miscompares++;
            $display("FAIL lone_latency got=%0d exp=1", hs);
        end
        r_phase(0, 15, 0, -1, 0, lows);
    endtask

    task automatic test_alternate();
        int hs, lows, exp;
        do_reset();
        i_r_addr = rand_line(); d_r_addr = rand_line();
        i_r_req = 1; d_r_req = 1;
        for (int n = 0; n < 4; n++) begin
            exp = pick(1, 1, m_last);
            ar_phase(exp, exp ? d_r_addr : i_r_addr, 0, 1, hs);
            r_phase(exp, 15, 0, -1, 0, lows);
        end
        i_r_req = 0; d_r_req = 0;
    endtask

    task automatic test_hazard();
        int hs, lows;
        do_reset();
        wb_cycle(1, 0, 32'h0000_2000);
        d_r_req = 1; d_r_addr = 32'h0000_2000;
        expect_no_ar(5, "hazard_block");
        i_r_req = 1; i_r_addr = 32'h0000_3000;
        ar_phase(0, 32'h0000_3000, 0, 0, hs);
        r_phase(0, 15, 0, -1, 0, lows);
        expect_no_ar(3, "hazard_still");
        mon_bvalid = 1; mon_bready = 1; arready = 1;
        #1;
        vectors++;
        if (arvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_b_cycle arvalid=%b exp=0", arvalid);
        end
        @(negedge clk);
        mon_bvalid = 0; mon_bready = 0;
        #1;
        vectors++;
        if (arvalid !== 1'b1 || d_r_rdy !== 1'b1 || araddr !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL hazard_release got arvalid=%b d_r_rdy=%b addr=%h exp 1/1/00002000", arvalid, d_r_rdy, araddr);
        end
        @(negedge clk);
        arready = 0; d_r_req = 0;
        r_phase(1, 15, 0, -1, 0, lows);
    endtask

    task automatic test_ready_stall();
        int hs, lows;
        do_reset();
        d_r_req = 1; d_r_addr = rand_line();
        ar_phase(1, d_r_addr, 0, 0, hs);
        r_phase(1, 15, 1, -1, 0, lows);
        vectors++;
        if (lows !== 3) begin
            miscompares++;
            $display("FAIL stall_cycles got=%0d exp=3", lows);
        end
    endtask

    task automatic test_protocol_err();
        int hs, lows;
        do_reset();
        i_r_req = 1; i_r_addr = rand_line();
        ar_phase(0, i_r_addr, 0, 0, hs);
        r_phase(0, 9, 0, -1, 0, lows);
        repeat (3) @(negedge clk);
        vectors++;
        if (protocol_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky got=%b exp=1", protocol_err);
        end
        do_reset();
        wb_cycle(1, 0, 32'h0000_4000);
        wb_cycle(1, 1, 32'h0000_5000);
        vectors++;
        if (protocol_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_aw_b got=%b exp=0", protocol_err);
        end
        d_r_req = 1; d_r_addr = 32'h0000_5000;
        expect_no_ar(4, "aw_b_newline");
        wb_cycle(0, 1, 32'h0);
        ar_phase(1, 32'h0000_5000, 0, 0, hs);
        r_phase(1, 15, 0, -1, 0, lows);
        wb_cycle(1, 0, 32'h0000_6000);
        wb_cycle(1, 0, 32'h0000_7000);
        m_err = 1;
        vectors++;
        if (protocol_err !== m_err) begin
            miscompares++;
            $display("FAIL err_dbl_aw got=%b exp=%b", protocol_err, m_err);
        end
    endtask

    task automatic test_reset_mid();
        int hs, lows;
        do_reset();
        d_r_req = 1; d_r_addr = rand_line();
        ar_phase(1, d_r_addr, 0, 0, hs);
        r_phase(1, 15, 0, 7, 0, lows);
        rst = 1;
        @(negedge clk);
        rst = 0; m_last = 0; m_err = 0;
        #1;
        vectors++;
        if ({arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, protocol_err} !== 9'b0
            || araddr !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset got=%b addr=%h exp all zero",
                     {arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, protocol_err}, araddr);
        end
        @(negedge clk);
        i_r_req = 1; i_r_addr = rand_line();
        ar_phase(0, i_r_addr, 0, 0, hs);
        r_phase(0, 15, 0, -1, 0, lows);
    endtask

    task automatic test_random();
        int          hs, lows, exp;
        bit          ri, rd, pend, ie, de;
        logic [31:0] wline;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            ri = $urandom_range(0, 1);
            rd = $urandom_range(0, 1);
            if (!ri && !rd) rd = 1;
            i_r_addr = rand_line();
            d_r_addr = ($urandom_range(0, 3) == 0) ? i_r_addr : rand_line();
            pend = $urandom_range(0, 1);
            wline = $urandom_range(0, 1) ? i_r_addr : d_r_addr;
            if (pend) wb_cycle(1, 0, wline | 32'($urandom_range(0, 63)));
            i_r_req = ri; d_r_req = rd;
            ie = ri && !(pend && i_r_addr[31:6] == wline[31:6]);
            de = rd && !(pend && d_r_addr[31:6] == wline[31:6]);
            exp = pick(ie, de, m_last);
            if (exp < 0) begin
                expect_no_ar(4, "rand_block");
                wb_cycle(0, 1, 32'h0);
                pend = 0;
                exp = pick(ri, rd, m_last);
            end
            ar_phase(exp, exp ? d_r_addr : i_r_addr, 0, 0, hs);
            r_phase(exp, 15, 0, -1, 1, lows);
            if (pend) wb_cycle(0, 1, 32'h0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_lone();
        test_alternate();
        test_hazard();
        test_ready_stall();
        test_protocol_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
